hvac_driver: RTL and testbench

HVAC_DRIVER -- requirements
Module: hvac_driver

---
 rtl/hvac_pkg.sv | 15 +
 rtl/hvac_tick_counter.sv | 36 +++
 rtl/hvac_driver.sv | 122 ++++++++++++
 tb/tb_hvac_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared constants for the HVAC driver: state encoding and default timing.
package hvac_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEAT    = 3'd1;
  localparam logic [2:0] ST_COOL    = 3'd2;
  localparam logic [2:0] ST_OVERRUN = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam int MIN_ON_DEF  = 4;
  localparam int MIN_OFF_DEF = 3;
  localparam int FAN_RUN_DEF = 2;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/hvac_tick_counter.sv
// Saturating tick counter with synchronous clear; clear wins over enable.
module hvac_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, hold at all-ones, or step by one on enable.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hvac_driver.sv
// HVAC heater/compressor/fan sequencer with minimum run time, fan overrun
// and restart lockout.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | all drives off, waiting for a single heat or cool request
// HEAT    | heater + fan; held for at least MIN_ON ticks
// COOL    | compressor + fan; held for at least MIN_ON ticks
// OVERRUN | fan only for FAN_RUN ticks, requests ignored
// LOCKOUT | all off for MIN_OFF ticks, requests ignored
module hvac_driver
  import hvac_pkg::*;
#(
  parameter int MIN_ON  = MIN_ON_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF,
  parameter int FAN_RUN = FAN_RUN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       tick_i,
  input  logic       heating_i,
  input  logic       cooling_i,
  output logic       heater_on_o,
  output logic       compressor_on_o,
  output logic       fan_on_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] FAN_RUN_C = CNT_W'(FAN_RUN);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             heater_q;
  logic             compressor_q;
  logic             fan_q;
  logic             fault_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             cnt_clr;
  logic             cnt_en;

  // The timed exits fire on the tick that would bring the count to its
  // target, so the target value itself is never stored.
  assign count_inc = count + 1'b1;
  assign cnt_clr   = (state_d != state_q);
  assign cnt_en    = tick_i && (state_q != ST_IDLE);

  hvac_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .count_o(count)
  );

  // Next-state logic; HEAT and COOL can only be left via OVERRUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (heating_i && !cooling_i) begin
          state_d = ST_HEAT;
        end else if (cooling_i && !heating_i) begin
          state_d = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (!heating_i && (count >= MIN_ON_C)) begin
          state_d = ST_OVERRUN;
        end
      end
      ST_COOL: begin
        if (!cooling_i && (count >= MIN_ON_C)) begin
          state_d = ST_OVERRUN;
        end
      end
      ST_OVERRUN: begin
        if (tick_i && (count_inc == FAN_RUN_C)) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (tick_i && (count_inc == MIN_OFF_C)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and drives registered together; drives decode the next state so
  // they line up with the state register and never glitch.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      heater_q     <= 1'b0;
      compressor_q <= 1'b0;
      fan_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      heater_q     <= (state_d == ST_HEAT);
      compressor_q <= (state_d == ST_COOL);
      fan_q        <= (state_d == ST_HEAT) || (state_d == ST_COOL) ||
                      (state_d == ST_OVERRUN);
      fault_q      <= heating_i && cooling_i;
    end
  end

  assign heater_on_o     = heater_q;
  assign compressor_on_o = compressor_q;
  assign fan_on_o        = fan_q;
  assign fault_o         = fault_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_hvac_driver.sv
// Directed bench for hvac_driver: the driver pushes the expected post-edge
// state and fault for each applied vector; the monitor pops and compares
// shortly after each rising edge.
module tb_hvac_driver;
  import hvac_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       flt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       heating;
  logic       cooling;
  logic       heater_on;
  logic       compressor_on;
  logic       fan_on;
  logic       fault;
  logic [2:0] state;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] I = ST_IDLE;
  localparam logic [2:0] H = ST_HEAT;
  localparam logic [2:0] C = ST_COOL;
  localparam logic [2:0] O = ST_OVERRUN;
  localparam logic [2:0] L = ST_LOCKOUT;

  // Narrow counter so the long cooling run also exercises saturation.
  hvac_driver #(
    .MIN_ON (4),
    .MIN_OFF(3),
    .FAN_RUN(2),
    .CNT_W  (3)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .tick_i         (tick),
    .heating_i      (heating),
    .cooling_i      (cooling),
    .heater_on_o    (heater_on),
    .compressor_on_o(compressor_on),
    .fan_on_o       (fan_on),
    .fault_o        (fault),
    .state_o        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one output set per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", state, e.st);
        chk("heater_on", {2'b0, heater_on}, {2'b0, e.st == H});
        chk("compressor_on", {2'b0, compressor_on}, {2'b0, e.st == C});
        chk("fan_on", {2'b0, fan_on}, {2'b0, (e.st == H) || (e.st == C) || (e.st == O)});
        chk("fault", {2'b0, fault}, {2'b0, e.flt});
        chk("no_overlap", {2'b0, heater_on & compressor_on}, 3'd0);
      end
    end
  end

  // Apply one vector before the next edge and record what must follow it.
  task automatic step(input logic r, input logic t, input logic h, input logic c,
                      input logic [2:0] st);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    tick    = t;
    heating = h;
    cooling = c;
    e.st  = st;
    e.flt = r & h & c;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    heating = 1'b0;
    cooling = 1'b0;

    // Reset state, including reset winning over tick and requests.
    step(0, 0, 0, 0, I);
    step(0, 1, 1, 1, I);
    step(1, 0, 0, 0, I);

    // Heat request, early release held to MIN_ON, overrun, lockout.
    step(1, 0, 1, 0, H);
    step(1, 1, 1, 0, H);
    step(1, 0, 0, 0, H);
    step(1, 1, 0, 0, H);
    step(1, 1, 0, 0, H);
    step(1, 1, 0, 0, H);
    step(1, 0, 0, 0, O);
    step(1, 1, 0, 0, O);
    step(1, 0, 0, 0, O);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 0, 0, 0, L);
    step(1, 1, 0, 0, I);
    step(1, 0, 0, 0, I);

    // Long cooling run (counter saturates), release, overrun, lockout.
    step(1, 0, 0, 1, C);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 1, C);
    step(1, 0, 0, 0, O);
    step(1, 1, 0, 0, O);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, I);

    // Heat to cool swap must pass through overrun and lockout.
    step(1, 0, 1, 0, H);
    for (int k = 0; k < 5; k++) step(1, 1, 1, 0, H);
    step(1, 0, 0, 1, O);
    step(1, 1, 0, 1, O);
    step(1, 1, 0, 1, L);
    step(1, 1, 0, 1, L);
    step(1, 1, 0, 1, L);
    step(1, 1, 0, 1, I);
    step(1, 0, 0, 1, C);

    // Reset two ticks into COOL, then re-entry with cooling still held.
    step(1, 1, 0, 1, C);
    step(1, 1, 0, 1, C);
    step(0, 1, 0, 1, I);
    step(1, 0, 0, 1, C);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 1, C);
    step(1, 0, 0, 0, O);
    step(1, 1, 0, 0, O);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 1, 0, 0, I);

    // Both requests in IDLE: stay, fault; release heat -> COOL, fault clears.
    step(1, 0, 1, 1, I);
    step(1, 1, 1, 1, I);
    step(1, 0, 0, 1, C);
    step(1, 1, 1, 1, C);
    step(1, 0, 1, 0, C);
    step(1, 1, 1, 0, C);
    step(1, 1, 1, 0, C);
    step(1, 1, 1, 0, C);
    step(1, 0, 1, 0, O);
    step(1, 1, 1, 0, O);
    step(1, 1, 1, 0, L);
    step(1, 1, 1, 0, L);
    step(1, 1, 1, 0, L);
    step(1, 1, 1, 0, I);
    step(1, 0, 1, 0, H);

    // Heating pulse in LOCKOUT ignored; held request enters HEAT after IDLE.
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, H);
    step(1, 0, 0, 0, O);
    step(1, 1, 0, 0, O);
    step(1, 1, 0, 0, L);
    step(1, 1, 1, 0, L);
    step(1, 0, 0, 0, L);
    step(1, 1, 0, 0, L);
    step(1, 0, 1, 0, L);
    step(1, 1, 1, 0, I);
    step(1, 0, 1, 0, H);

    // Reset mid-HEAT drops drives immediately.
    step(1, 1, 1, 0, H);
    step(0, 0, 1, 0, I);
    step(1, 0, 0, 0, I);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 3'(sb.size()), 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
